softmax_bram_seq: RTL and testbench
===================================

Name: softmax_bram_seq

Overview:
- Parametrised successor to the single-pass BRAM-to-softmax sequencer.
- Streams a programmable window of rows from BRAM port B into softmax_approx and writes each result back through port A to a separate destination window.
- Throttles issue with a credit limit and carries each row's length-mode through a small FIFO, so results are written back with their own mode.
- Sits between the dual-port BRAM and softmax_approx, under a host/controller that pulses start.

Parameters:
DATA_W, 1024, softmax vector width (in_x_flat / prob_flat)
MODE_W, 4, length-mode field width stored in upper bits of each BRAM row
ADDR_W, 5, BRAM address width; BRAM depth = 2**ADDR_W
MAX_INFLIGHT, 4, max rows issued to softmax but not yet written back (power of 2, >=1)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  global enable; low freezes all state
i_start  in  1  start pulse; sampled only in IDLE
i_src_base  in  ADDR_W  first source row address
i_dst_base  in  ADDR_W  first destination row address
i_row_cnt  in  ADDR_W+1  number of rows to process (0..2**ADDR_W)
o_busy  out  1  high from accepted start until done
o_done  out  1  one-cycle pulse when last result is written
o_err  out  1  sticky: result arrived with mode FIFO empty; cleared by next accepted start
o_cena, o_wea  out  1  port A enable / write enable
o_addra  out  ADDR_W  port A address
o_dina  out  DATA_W+MODE_W  {mode, prob}
o_cenb  out  1  port B enable
o_addrb  out  ADDR_W  port B address
i_doutb  in  DATA_W+MODE_W  port B data; 1-cycle read latency
o_length_mode  out  MODE_W  mode to softmax
o_valid  out  1  input-valid pulse to softmax
o_in_x_flat  out  DATA_W  input vector to softmax
i_valid  in  1  result valid from softmax
i_prob_flat  in  DATA_W  result from softmax

Behaviour:
- Reset (async, i_rst_n=0): state IDLE. All outputs 0. Counters, credit count, FIFO pointers and o_err cleared. Reset mid-run abandons the run; no done pulse.
- i_en=0: no state, counter, FIFO or output register changes. Registered outputs hold their values.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - i_start=1 latches bases and count, clears o_err and rd_cnt/wr_cnt, sets o_busy.
  - Goes to RUN, or to DONE if i_row_cnt=0 (no BRAM access).
  - i_start outside IDLE is ignored.
- RUN, issue rule: issue a read when rd_cnt < row_cnt and inflight < MAX_INFLIGHT.
  - On issue: o_cenb=1, o_addrb = src_base + rd_cnt (mod 2**ADDR_W), rd_cnt++.
  - One cycle after issue: o_valid=1, o_in_x_flat = i_doutb[DATA_W-1:0], o_length_mode = i_doutb[DATA_W+MODE_W-1:DATA_W]. The mode is pushed into the mode FIFO (depth MAX_INFLIGHT).
  - inflight counts issued reads not yet written back. It increments on issue and decrements on i_valid; both in the same cycle leave it unchanged.
  - RUN -> DRAIN when rd_cnt reaches row_cnt.
- Write-back (RUN or DRAIN), same cycle as i_valid=1:
  - o_cena=o_wea=1, o_addra = dst_base + wr_cnt (mod 2**ADDR_W), o_dina = {fifo_head, i_prob_flat}. Pop FIFO, wr_cnt++.
  - FIFO empty at i_valid: write mode 0, set o_err, still count the row.
  - Simultaneous FIFO push and pop is legal.
  - i_valid in IDLE/DONE: ignored, no write.
- DRAIN -> DONE when wr_cnt reaches row_cnt.
- DONE: o_done=1 for one cycle, o_busy drops, then IDLE.
- Address wrap: source and destination windows wrap modulo depth independently. Overlapping windows are legal; the issue order is strictly ascending.
- Throughput: with softmax latency L, one row per cycle when MAX_INFLIGHT >= L+1; otherwise credit-limited.

Optional Feature:
SOFTMAX_BRAM_SEQ_PERF_EN
- Defined: adds output o_cycles [15:0]. It clears on accepted start, increments each enabled cycle while o_busy, saturates at 16'hFFFF, and holds after done.
- Undefined: port and counter are absent.

Test Plan:
- src=0, dst=16, cnt=4, softmax L=3, MAX_INFLIGHT=4 -> reads at 0..3 on consecutive cycles; writes at 16..19 with {mode_k, prob_k}; one o_done; o_busy low afterwards.
- cnt=0 -> o_done pulse 2 cycles after start; o_cenb/o_cena never asserted.
- MAX_INFLIGHT=1, cnt=3 -> next read issues only in the cycle of the previous write-back; inflight never exceeds 1.
- src=30, dst=31, cnt=4 -> read addresses 30,31,0,1; write addresses 31,0,1,2.
- Assert i_rst_n=0 after 2 writes of cnt=8 -> all outputs 0 immediately; no o_done; a new start runs cleanly.
- Inject a spurious i_valid with no outstanding row -> o_err=1 and a write with mode 0; o_err clears on the next start.

Source files
------------

// File: rtl/softmax_bram_seq_if.sv
// BRAM port A/B and softmax_approx streaming signals driven or consumed by softmax_bram_seq.
interface softmax_bram_seq_if #(
  parameter int DATA_W = 1024,
  parameter int MODE_W = 4,
  parameter int ADDR_W = 5
);
  logic                     cena;
  logic                     wea;
  logic [ADDR_W-1:0]        addra;
  logic [DATA_W+MODE_W-1:0] dina;
  logic                     cenb;
  logic [ADDR_W-1:0]        addrb;
  logic [DATA_W+MODE_W-1:0] doutb;
  logic [MODE_W-1:0]        length_mode;
  logic                     x_vld;
  logic [DATA_W-1:0]        in_x_flat;
  logic                     prob_vld;
  logic [DATA_W-1:0]        prob_flat;

  modport master (
    output cena, wea, addra, dina, cenb, addrb, length_mode, x_vld, in_x_flat,
    input  doutb, prob_vld, prob_flat
  );

  modport slave (
    input  cena, wea, addra, dina, cenb, addrb, length_mode, x_vld, in_x_flat,
    output doutb, prob_vld, prob_flat
  );
endinterface

// File: rtl/softmax_bram_seq.sv
// Credit-limited BRAM -> softmax_approx -> BRAM row sequencer; each row's mode rides a small FIFO.
// Define SOFTMAX_BRAM_SEQ_PERF_EN to add the saturating o_cycles busy-cycle counter.
module softmax_bram_seq #(
  parameter int DATA_W       = 1024,
  parameter int MODE_W       = 4,
  parameter int ADDR_W       = 5,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src_base,
  input  logic [ADDR_W-1:0] i_dst_base,
  input  logic [ADDR_W:0]   i_row_cnt,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
`ifdef SOFTMAX_BRAM_SEQ_PERF_EN
  output logic [15:0]       o_cycles,
`endif
  softmax_bram_seq_if.master io_bus
);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int IW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [CW-1:0]     MAX_C   = CW'(MAX_INFLIGHT);
  localparam logic [CW-1:0]     ONE_C   = CW'(1);
  localparam logic [IW-1:0]     LAST_P  = IW'(MAX_INFLIGHT - 1);
  localparam logic [IW-1:0]     ONE_P   = IW'(1);
  localparam logic [ADDR_W:0]   ONE_R   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_src_base, r_dst_base;
  logic [ADDR_W:0]   r_row_cnt, r_rd_cnt, r_wr_cnt;
  logic [CW-1:0]     r_inflight, r_fifo_cnt;
  logic [IW-1:0]     r_fifo_wp, r_fifo_rp;
  logic [MODE_W-1:0] r_fifo_mem [2**IW];
  logic              r_x_vld, r_busy, r_done, r_err;

  logic              w_start, w_active, w_wb, w_credit, w_issue;
  logic              w_push, w_pop, w_fifo_empty, w_rd_last, w_wr_last;
  logic [MODE_W-1:0] w_head;

  assign w_start      = i_en & i_start & (r_state == S_IDLE);
  assign w_active     = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign w_wb         = i_en & w_active & io_bus.prob_vld;
  // A write-back in this cycle frees its credit for a read in the same cycle.
  assign w_credit     = (r_inflight < MAX_C) | (w_wb & (r_inflight != '0));
  assign w_issue      = i_en & (r_state == S_RUN) & (r_rd_cnt < r_row_cnt) & w_credit;
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_pop        = w_wb & ~w_fifo_empty;
  assign w_push       = i_en & r_x_vld & ((r_fifo_cnt != MAX_C) | w_pop);
  assign w_head       = w_fifo_empty ? '0 : r_fifo_mem[r_fifo_rp];
  assign w_rd_last    = w_issue & ((r_rd_cnt + ONE_R) == r_row_cnt);
  assign w_wr_last    = (w_wb & ((r_wr_cnt + ONE_R) >= r_row_cnt)) | (r_wr_cnt >= r_row_cnt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else if (i_en) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = (i_row_cnt == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_rd_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_wr_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    io_bus.cenb        = w_issue;
    io_bus.addrb       = w_issue ? (r_src_base + r_rd_cnt[ADDR_W-1:0]) : '0;
    io_bus.cena        = w_wb;
    io_bus.wea         = w_wb;
    io_bus.addra       = w_wb ? (r_dst_base + r_wr_cnt[ADDR_W-1:0]) : '0;
    io_bus.dina        = w_wb ? {w_head, io_bus.prob_flat} : '0;
    io_bus.x_vld       = r_x_vld;
    io_bus.in_x_flat   = r_x_vld ? io_bus.doutb[DATA_W-1:0] : '0;
    io_bus.length_mode = r_x_vld ? io_bus.doutb[DATA_W+MODE_W-1:DATA_W] : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src_base <= '0;
      r_dst_base <= '0;
      r_row_cnt  <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_inflight <= '0;
      r_fifo_cnt <= '0;
      r_fifo_wp  <= '0;
      r_fifo_rp  <= '0;
      r_x_vld    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (i_en) begin
      r_x_vld <= w_issue;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (r_state == S_DONE);
      if (w_start) begin
        // Stale FIFO entries from an aborted or faulty run must not leak into this one.
        r_src_base <= i_src_base;
        r_dst_base <= i_dst_base;
        r_row_cnt  <= i_row_cnt;
        r_rd_cnt   <= '0;
        r_wr_cnt   <= '0;
        r_inflight <= '0;
        r_fifo_cnt <= '0;
        r_fifo_wp  <= '0;
        r_fifo_rp  <= '0;
        r_err      <= 1'b0;
      end else begin
        if (w_issue) r_rd_cnt <= r_rd_cnt + ONE_R;
        if (w_wb) begin
          r_wr_cnt <= r_wr_cnt + ONE_R;
          if (w_fifo_empty) r_err <= 1'b1;
        end
        if (w_issue && !(w_wb && r_inflight != '0)) r_inflight <= r_inflight + ONE_C;
        else if (!w_issue && w_wb && r_inflight != '0) r_inflight <= r_inflight - ONE_C;
        if (w_push) r_fifo_wp <= (r_fifo_wp == LAST_P) ? '0 : r_fifo_wp + ONE_P;
        if (w_pop)  r_fifo_rp <= (r_fifo_rp == LAST_P) ? '0 : r_fifo_rp + ONE_P;
        if (w_push && !w_pop) r_fifo_cnt <= r_fifo_cnt + ONE_C;
        else if (w_pop && !w_push) r_fifo_cnt <= r_fifo_cnt - ONE_C;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !w_start) r_fifo_mem[r_fifo_wp] <= io_bus.doutb[DATA_W+MODE_W-1:DATA_W];
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_err  = r_err;

`ifdef SOFTMAX_BRAM_SEQ_PERF_EN
  logic [15:0] r_cycles;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cycles <= '0;
    else if (i_en) begin
      if (w_start) r_cycles <= '0;
      else if (r_busy && r_cycles != 16'hFFFF) r_cycles <= r_cycles + 16'd1;
    end
  end
  assign o_cycles = r_cycles;
`endif
endmodule

// File: tb/tb_softmax_bram_seq.sv
// Bench for softmax_bram_seq: two instances (credit 4 and credit 1) with BRAM and 3-stage softmax models.
module tb_softmax_bram_seq;
  localparam int DW = 16;
  localparam int MW = 4;
  localparam int AW = 5;
  typedef logic [AW+MW+DW-1:0] wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [AW-1:0] src = '0, dst = '0;
  logic [AW:0]   cnt = '0;
  logic busy0, done0, err0, busy1, done1, err1;
  logic inj_vld = 1'b0;
  logic [DW-1:0] inj_dat = '0;

  logic [DW+MW-1:0] pat [32];
  logic [2:0] sv0 = '0, sv1 = '0;
  logic [DW-1:0] sd0 [3], sd1 [3];

  int checks = 0;
  int errors = 0;
  wr_t exp_q[$];
  int  exp_rd_q[$];
  wr_t obs_wr[$];
  int  obs_rd[$];
  int  obs_rd_cyc[$];
  int  n_done, done_cyc, max_infl, rd_wo_wb;

  softmax_bram_seq_if #(.DATA_W(DW), .MODE_W(MW), .ADDR_W(AW)) b0 ();
  softmax_bram_seq_if #(.DATA_W(DW), .MODE_W(MW), .ADDR_W(AW)) b1 ();

  softmax_bram_seq #(.DATA_W(DW), .MODE_W(MW), .ADDR_W(AW), .MAX_INFLIGHT(4)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start0),
    .i_src_base(src), .i_dst_base(dst), .i_row_cnt(cnt),
    .o_busy(busy0), .o_done(done0), .o_err(err0), .io_bus(b0.master));

  softmax_bram_seq #(.DATA_W(DW), .MODE_W(MW), .ADDR_W(AW), .MAX_INFLIGHT(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_start(start1),
    .i_src_base(src), .i_dst_base(dst), .i_row_cnt(cnt),
    .o_busy(busy1), .o_done(done1), .o_err(err1), .io_bus(b1.master));

  always #5 clk = ~clk;

  // BRAM read port and a latency-3 softmax stand-in that returns the bitwise inverse of its input.
  always @(posedge clk) begin
    if (b0.cenb) b0.doutb <= pat[b0.addrb];
    if (b1.cenb) b1.doutb <= pat[b1.addrb];
    sv0 <= {sv0[1:0], b0.x_vld};
    sv1 <= {sv1[1:0], b1.x_vld};
    sd0[0] <= ~b0.in_x_flat; sd0[1] <= sd0[0]; sd0[2] <= sd0[1];
    sd1[0] <= ~b1.in_x_flat; sd1[1] <= sd1[0]; sd1[2] <= sd1[1];
  end
  assign b0.prob_vld  = sv0[2] | inj_vld;
  assign b0.prob_flat = inj_vld ? inj_dat : sd0[2];
  assign b1.prob_vld  = sv1[2];
  assign b1.prob_flat = sd1[2];

  task automatic fill();
    for (int a = 0; a < 32; a++) pat[a] = {MW'(a ^ 5), DW'($urandom)};
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_start(input int inst, input int s, input int d, input int n);
    logic [DW+MW-1:0] m;
    src = AW'(s); dst = AW'(d); cnt = (AW+1)'(n);
    for (int k = 0; k < n; k++) begin
      m = pat[(s + k) % 32];
      exp_rd_q.push_back((s + k) % 32);
      exp_q.push_back({AW'((d + k) % 32), m[DW+MW-1:DW], ~m[DW-1:0]});
    end
    @(posedge clk); #1;
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
  endtask

  // Records port activity per cycle; c=0 is the first cycle after start is accepted.
  task automatic watch(input int inst, input int budget, input int stop_wr);
    logic cb, ca, we, dn;
    logic [AW-1:0] ab, aa;
    logic [DW+MW-1:0] da;
    int infl = 0;
    obs_wr.delete(); obs_rd.delete(); obs_rd_cyc.delete();
    n_done = 0; done_cyc = -1; max_infl = 0; rd_wo_wb = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cb = (inst == 0) ? b0.cenb  : b1.cenb;
      ab = (inst == 0) ? b0.addrb : b1.addrb;
      ca = (inst == 0) ? b0.cena  : b1.cena;
      we = (inst == 0) ? b0.wea   : b1.wea;
      aa = (inst == 0) ? b0.addra : b1.addra;
      da = (inst == 0) ? b0.dina  : b1.dina;
      dn = (inst == 0) ? done0    : done1;
      if (cb) begin
        if (obs_rd.size() > 0 && !ca) rd_wo_wb++;
        obs_rd.push_back(int'(ab)); obs_rd_cyc.push_back(c); infl++;
      end
      if (ca && we) begin obs_wr.push_back({aa, da}); infl--; end
      if (infl > max_infl) max_infl = infl;
      if (dn) begin n_done++; done_cyc = c; end
      if (stop_wr > 0 && obs_wr.size() >= stop_wr) break;
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
  endtask

  task automatic test_reset();
    logic [63:0] v;
    #2;
    v = {b0.cena, b0.wea, b0.cenb, b0.x_vld, busy0, done0, err0, b0.addra, b0.addrb,
         b0.dina, b0.in_x_flat, b0.length_mode};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL reset_outs0 got %0h want 0", v); end
    v = {b1.cena, b1.cenb, b1.x_vld, busy1, done1, err1};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL reset_outs1 got %0h want 0", v); end
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", busy0); end
  endtask

  task automatic test_main();
    fill();
    drive_start(0, 0, 16, 4);
    watch(0, 60, 0);
    checks++;
    if (obs_rd.size() != 4) begin errors++; $display("FAIL main_nrd got %0d want 4", obs_rd.size()); end
    for (int k = 0; k < obs_rd.size() && k < 4; k++) begin
      checks++;
      if (obs_rd_cyc[k] != k) begin errors++; $display("FAIL main_rd_cyc%0d got %0d want %0d", k, obs_rd_cyc[k], k); end
    end
    while (exp_rd_q.size() > 0 && obs_rd.size() > 0) begin
      int e, o; e = exp_rd_q.pop_front(); o = obs_rd.pop_front(); checks++;
      if (o != e) begin errors++; $display("FAIL main_rd_addr got %0d want %0d", o, e); end
    end
    checks++;
    if (obs_wr.size() != exp_q.size()) begin errors++; $display("FAIL main_nwr got %0d want %0d", obs_wr.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_wr.size() > 0) begin
      wr_t e, o; e = exp_q.pop_front(); o = obs_wr.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL main_wr got %0h want %0h", o, e); end
    end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL main_done got %0d want 1", n_done); end
    checks++;
    if (busy0 !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL main_busy_err got %0b%0b want 00", busy0, err0); end
    exp_q.delete(); exp_rd_q.delete();
    idle(6);
  endtask

  task automatic test_zero_rows();
    drive_start(0, 3, 3, 0);
    watch(0, 12, 0);
    checks++;
    if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cyc got %0d want 1", done_cyc); end
    checks++;
    if (obs_rd.size() + obs_wr.size() != 0) begin errors++; $display("FAIL zero_access got %0d want 0", obs_rd.size() + obs_wr.size()); end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL zero_ndone got %0d want 1", n_done); end
    idle(4);
  endtask

  task automatic test_credit();
    fill();
    drive_start(1, 4, 20, 3);
    watch(1, 80, 0);
    checks++;
    if (rd_wo_wb != 0) begin errors++; $display("FAIL credit_rd_no_wb got %0d want 0", rd_wo_wb); end
    checks++;
    if (max_infl > 1) begin errors++; $display("FAIL credit_inflight got %0d want <=1", max_infl); end
    checks++;
    if (obs_rd_cyc.size() < 2 || obs_rd_cyc[1] != 4) begin errors++; $display("FAIL credit_rd1_cyc got %0d reads want second at 4", obs_rd_cyc.size()); end
    checks++;
    if (obs_wr.size() != exp_q.size()) begin errors++; $display("FAIL credit_nwr got %0d want %0d", obs_wr.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_wr.size() > 0) begin
      wr_t e, o; e = exp_q.pop_front(); o = obs_wr.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL credit_wr got %0h want %0h", o, e); end
    end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL credit_done got %0d want 1", n_done); end
    exp_q.delete(); exp_rd_q.delete();
    idle(6);
  endtask

  task automatic test_wrap();
    fill();
    drive_start(0, 30, 31, 4);
    watch(0, 60, 0);
    checks++;
    if (obs_rd.size() != exp_rd_q.size()) begin errors++; $display("FAIL wrap_nrd got %0d want %0d", obs_rd.size(), exp_rd_q.size()); end
    while (exp_rd_q.size() > 0 && obs_rd.size() > 0) begin
      int e, o; e = exp_rd_q.pop_front(); o = obs_rd.pop_front(); checks++;
      if (o != e) begin errors++; $display("FAIL wrap_rd_addr got %0d want %0d", o, e); end
    end
    while (exp_q.size() > 0 && obs_wr.size() > 0) begin
      wr_t e, o; e = exp_q.pop_front(); o = obs_wr.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL wrap_wr got %0h want %0h", o, e); end
    end
    checks++;
    if (exp_q.size() != 0 || n_done != 1) begin errors++; $display("FAIL wrap_end got %0d left %0d done want 0 1", exp_q.size(), n_done); end
    exp_q.delete(); exp_rd_q.delete();
    idle(6);
  endtask

  task automatic test_reset_midrun();
    logic [63:0] v;
    fill();
    drive_start(0, 0, 16, 8);
    watch(0, 60, 2);
    checks++;
    if (obs_wr.size() != 2) begin errors++; $display("FAIL rst_pre_writes got %0d want 2", obs_wr.size()); end
    rst_n = 1'b0;
    #1;
    v = {b0.cena, b0.wea, b0.cenb, b0.x_vld, busy0, done0, err0, b0.addra, b0.addrb,
         b0.dina, b0.in_x_flat, b0.length_mode};
    checks++;
    if (v !== '0) begin errors++; $display("FAIL rst_mid_outs got %0h want 0", v); end
    exp_q.delete(); exp_rd_q.delete();
    idle(3);
    rst_n = 1'b1;
    watch(0, 8, 0);
    checks++;
    if (n_done != 0 || obs_wr.size() != 0) begin errors++; $display("FAIL rst_after got %0d done %0d wr want 0 0", n_done, obs_wr.size()); end
    drive_start(0, 0, 16, 8);
    watch(0, 80, 0);
    checks++;
    if (obs_wr.size() != exp_q.size()) begin errors++; $display("FAIL rst_rerun_nwr got %0d want %0d", obs_wr.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_wr.size() > 0) begin
      wr_t e, o; e = exp_q.pop_front(); o = obs_wr.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rst_rerun_wr got %0h want %0h", o, e); end
    end
    checks++;
    if (n_done != 1) begin errors++; $display("FAIL rst_rerun_done got %0d want 1", n_done); end
    exp_q.delete(); exp_rd_q.delete();
    idle(6);
  endtask

  task automatic test_spurious();
    wr_t o;
    fill();
    drive_start(0, 8, 24, 1);
    exp_q.delete(); exp_rd_q.delete();
    inj_vld = 1'b1; inj_dat = 16'hBEEF;
    @(negedge clk);
    o = {b0.addra, b0.dina};
    checks++;
    if (b0.cena !== 1'b1 || o !== {5'd24, 4'h0, 16'hBEEF}) begin
      errors++; $display("FAIL spur_write got %0b %0h want 1 %0h", b0.cena, o, {5'd24, 4'h0, 16'hBEEF});
    end
    @(posedge clk); #1; inj_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (err0 !== 1'b1) begin errors++; $display("FAIL spur_err_set got %0b want 1", err0); end
    watch(0, 30, 0);
    checks++;
    if (n_done != 1 || obs_wr.size() != 0) begin errors++; $display("FAIL spur_end got %0d done %0d wr want 1 0", n_done, obs_wr.size()); end
    checks++;
    if (err0 !== 1'b1) begin errors++; $display("FAIL spur_err_sticky got %0b want 1", err0); end
    idle(6);
    drive_start(0, 2, 12, 2);
    @(negedge clk);
    checks++;
    if (err0 !== 1'b0) begin errors++; $display("FAIL spur_err_clear got %0b want 0", err0); end
    watch(0, 40, 0);
    while (exp_q.size() > 0 && obs_wr.size() > 0) begin
      wr_t e, w; e = exp_q.pop_front(); w = obs_wr.pop_front(); checks++;
      if (w !== e) begin errors++; $display("FAIL spur_rerun_wr got %0h want %0h", w, e); end
    end
    checks++;
    if (exp_q.size() != 0 || err0 !== 1'b0) begin errors++; $display("FAIL spur_rerun_end got %0d left err %0b want 0 0", exp_q.size(), err0); end
    exp_q.delete(); exp_rd_q.delete();
  endtask

  initial begin
    test_reset();
    test_main();
    test_zero_rows();
    test_credit();
    test_wrap();
    test_reset_midrun();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
